// File: rtl/rast_hit_merge.sv
// Merges two rasterizer hit ports into one in-order valid/ready stream through a shared circular buffer.
// Optional hit/drop statistics counters are enabled by defining RAST_HIT_MERGE_STATS_EN.
module rast_hit_merge #(
  parameter int SIGFIG = 24,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [SIGFIG*AXIS-1:0]   hit_R18S,
  input  logic        [SIGFIG*COLORS-1:0] color_R18U,
  input  logic                            hit_valid_R18H,
  input  logic signed [SIGFIG*AXIS-1:0]   hit_R18S2,
  input  logic        [SIGFIG*COLORS-1:0] color_R18U2,
  input  logic                            hit_valid_R18H2,
  output logic signed [SIGFIG*AXIS-1:0]   hit_R19S,
  output logic        [SIGFIG*COLORS-1:0] color_R19U,
  output logic                            hit_valid_R19H,
  input  logic                            hit_ready_R19H,
  output logic                            almost_full_R19H,
  output logic                            overflow_R19H
`ifdef RAST_HIT_MERGE_STATS_EN
  ,
  output logic [31:0]                     hit_count_R19U,
  output logic [31:0]                     drop_count_R19U
`endif
);

  localparam int HW = SIGFIG * AXIS;
  localparam int CLW = SIGFIG * COLORS;
  localparam int EW = HW + CLW;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_addr2;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] free;
  logic          almost_full_q;
  logic          overflow_q;
  logic          store1, store2, pop;
  logic [1:0]    n_push, n_stored, n_drop;

  // Free space is judged on the pre-pop count: a pop never makes room for a same-cycle push.
  always_comb begin
    free     = CW'(DEPTH) - count_q;
    store1   = hit_valid_R18H && (free != '0);
    store2   = hit_valid_R18H2 && (hit_valid_R18H ? (free >= CW'(2)) : (free != '0));
    n_push   = {1'b0, hit_valid_R18H} + {1'b0, hit_valid_R18H2};
    n_stored = {1'b0, store1} + {1'b0, store2};
    n_drop   = n_push - n_stored;
    wr_addr2 = hit_valid_R18H ? wr_ptr_q + AW'(1) : wr_ptr_q;
    pop      = (count_q != '0) && hit_ready_R19H;
    wr_ptr_d = wr_ptr_q + AW'(n_stored);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(n_stored) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      almost_full_q <= (count_d >= CW'(DEPTH - 2));
      overflow_q    <= overflow_q | (n_drop != 2'd0);
    end
  end

  // NOTE: storage has no reset; entries are only ever read once count says they were written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (store1) mem_q[wr_ptr_q] <= {hit_R18S, color_R18U};
      if (store2) mem_q[wr_addr2] <= {hit_R18S2, color_R18U2};
    end
  end

  assign hit_valid_R19H   = (count_q != '0);
  assign almost_full_R19H = almost_full_q;
  assign overflow_R19H    = overflow_q;
  assign {hit_R19S, color_R19U} = hit_valid_R19H ? mem_q[rd_ptr_q] : '0;

`ifdef RAST_HIT_MERGE_STATS_EN
  logic [31:0] hit_cnt_q, drop_cnt_q;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= sat_add(hit_cnt_q, n_stored);
      drop_cnt_q <= sat_add(drop_cnt_q, n_drop);
    end
  end

  assign hit_count_R19U  = hit_cnt_q;
  assign drop_count_R19U = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rast_hit_merge.sv
// Scoreboard bench for rast_hit_merge: a queue model decides which hits are kept and a negedge monitor checks the stream.
module tb_rast_hit_merge;
  localparam int SIGFIG = 24;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int DEPTH  = 8;
  localparam int HW  = SIGFIG * AXIS;
  localparam int CLW = SIGFIG * COLORS;

  typedef struct packed {
    logic [HW-1:0]  hit;
    logic [CLW-1:0] color;
  } hit_t;

  logic clk = 1'b0;
  logic rst;
  logic signed [HW-1:0] hit_R18S, hit_R18S2, hit_R19S;
  logic [CLW-1:0] color_R18U, color_R18U2, color_R19U;
  logic hit_valid_R18H, hit_valid_R18H2, hit_valid_R19H, hit_ready_R19H;
  logic almost_full_R19H, overflow_R19H;
`ifdef RAST_HIT_MERGE_STATS_EN
  logic [31:0] hit_count_R19U, drop_count_R19U;
`endif

  rast_hit_merge #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .hit_R18S(hit_R18S), .color_R18U(color_R18U), .hit_valid_R18H(hit_valid_R18H),
    .hit_R18S2(hit_R18S2), .color_R18U2(color_R18U2), .hit_valid_R18H2(hit_valid_R18H2),
    .hit_R19S(hit_R19S), .color_R19U(color_R19U), .hit_valid_R19H(hit_valid_R19H),
    .hit_ready_R19H(hit_ready_R19H), .almost_full_R19H(almost_full_R19H),
    .overflow_R19H(overflow_R19H)
`ifdef RAST_HIT_MERGE_STATS_EN
    , .hit_count_R19U(hit_count_R19U), .drop_count_R19U(drop_count_R19U)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: sb holds hits the DUT currently buffers; pend holds hits accepted this cycle.
  hit_t sb[$];
  hit_t pend[$];
  bit   ovf_m, ovf_pend, clear_next;
  longint hits_m, drops_m, hits_pend, drops_pend;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic hit_t mk(input int x, input int y, input int z,
                              input int r, input int g, input int b);
    hit_t h;
    h.hit   = {24'(z), 24'(y), 24'(x)};
    h.color = {24'(b), 24'(g), 24'(r)};
    return h;
  endfunction

  function automatic hit_t rnd_hit();
    logic [95:0] a, c;
    hit_t h;
    a = {$urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom};
    h.hit   = a[HW-1:0];
    h.color = c[CLW-1:0];
    return h;
  endfunction

  task automatic step(input bit v1, input bit v2, input bit rdy, input bit rs,
                      input hit_t d1, input hit_t d2);
    int slots;
    @(posedge clk);
    #1;
    if (clear_next) begin
      sb.delete(); pend.delete();
      ovf_m = 0; ovf_pend = 0; hits_m = 0; drops_m = 0; hits_pend = 0; drops_pend = 0;
      clear_next = 0;
    end else begin
      foreach (pend[i]) sb.push_back(pend[i]);
      pend.delete();
      ovf_m = ovf_m | ovf_pend; ovf_pend = 0;
      hits_m += hits_pend; drops_m += drops_pend; hits_pend = 0; drops_pend = 0;
    end
    rst = rs;
    hit_valid_R18H = v1; hit_R18S = d1.hit; color_R18U = d1.color;
    hit_valid_R18H2 = v2; hit_R18S2 = d2.hit; color_R18U2 = d2.color;
    hit_ready_R19H = rdy;
    if (rs) begin
      clear_next = 1;
    end else begin
      // Hits take free slots in port order; anything beyond the free space is lost.
      slots = DEPTH - sb.size();
      if (v1) begin
        if (slots > 0) begin pend.push_back(d1); slots--; hits_pend++; end
        else begin ovf_pend = 1; drops_pend++; end
      end
      if (v2) begin
        if (slots > 0) begin pend.push_back(d2); slots--; hits_pend++; end
        else begin ovf_pend = 1; drops_pend++; end
      end
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, rdy, 0, '0, '0);
  endtask

  always @(negedge clk) begin
    hit_t e;
    if (!rst) begin
      check("valid", hit_valid_R19H, sb.size() != 0);
      check("almost_full", almost_full_R19H, sb.size() >= DEPTH - 2);
      check("overflow", overflow_R19H, ovf_m);
`ifdef RAST_HIT_MERGE_STATS_EN
      check("hit_count", hit_count_R19U, hits_m);
      check("drop_count", drop_count_R19U, drops_m);
`endif
      if (hit_valid_R19H && hit_ready_R19H && sb.size() != 0) begin
        e = sb.pop_front();
        check("data", {hit_R19S, color_R19U}, e);
      end else if (!hit_valid_R19H) begin
        check("idle_data", {hit_R19S, color_R19U}, '0);
      end
    end
  end

  initial begin
    rst = 1; hit_ready_R19H = 0;
    hit_valid_R18H = 0; hit_valid_R18H2 = 0;
    hit_R18S = '0; hit_R18S2 = '0; color_R18U = '0; color_R18U2 = '0;
    ovf_m = 0; ovf_pend = 0; clear_next = 0;
    hits_m = 0; drops_m = 0; hits_pend = 0; drops_pend = 0;

    step(0, 0, 0, 1, '0, '0);
    step(1, 1, 1, 1, rnd_hit(), rnd_hit());
    idle(1, 1);

    // Single port-1 hit with ready high.
    step(1, 0, 1, 0, mk(5, 7, 1, 'h10, 'h20, 'h30), '0);
    idle(3, 1);

    // Fill with dual hits, ready low; then one fully dropped cycle.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, rnd_hit(), rnd_hit());
    step(1, 1, 0, 0, rnd_hit(), rnd_hit());
    // One pop brings count to 7, then a dual hit keeps only port 1.
    idle(1, 1);
    step(1, 1, 0, 0, rnd_hit(), rnd_hit());
    idle(10, 1);

    // Port 2 only, values 1..12, ready alternating, crossing the pointer wrap.
    for (int i = 1; i <= 12; i++) step(0, 1, (i % 2) == 1, 0, '0, mk(i, 0, 0, i, 0, 0));
    idle(10, 1);

    // Reset with five hits buffered; offered hits during reset are ignored.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, rnd_hit(), '0);
    step(1, 1, 1, 1, rnd_hit(), rnd_hit());
    idle(2, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) != 0,
           $urandom_range(0, 199) == 0, rnd_hit(), rnd_hit());
    idle(12, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
